// File: rtl/reg_pipe_pkg.sv
// Shared defaults and sizing helpers for the elastic register pipeline.
package reg_pipe_pkg;

    localparam int          DEF_WIDTH     = 8;
    localparam int          DEF_DEPTH     = 3;
    localparam logic [63:0] DEF_RESET_VAL = 64'h0000_0000_0000_0000;

    function automatic int occ_width(input int depth);
        if (depth < 32'sd1) begin
            return 32'sd1;
        end else begin
            return $clog2(depth + 32'sd1);
        end
    endfunction

endpackage

// File: rtl/reg_pipe_stage.sv
// One pipeline slot: valid bit plus data register with load/hold/flush behaviour.
module reg_pipe_stage
    import reg_pipe_pkg::*;
#(
    parameter int               WIDTH     = DEF_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VAL = DEF_RESET_VAL[WIDTH-1:0]
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             i_ready,
    input  logic             i_up_valid,
    input  logic [WIDTH-1:0] i_up_data,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data,
    output logic             o_valid_nxt
);

    logic             r_valid;
    logic [WIDTH-1:0] r_data;
    logic             w_valid_nxt;
    logic             w_load;

    // Next-state of the slot; data only moves when a valid item arrives.
    always_comb begin
        w_valid_nxt = r_valid;
        w_load      = 1'b0;
        if (flush) begin
            w_valid_nxt = 1'b0;
        end else if (i_ready) begin
            w_valid_nxt = i_up_valid;
            w_load      = i_up_valid;
        end else begin
            w_valid_nxt = r_valid;
        end
    end

    // Slot state register; reset dominates flush and transfers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= RESET_VAL;
        end else begin
            r_valid <= w_valid_nxt;
            if (w_load) begin
                r_data <= i_up_data;
            end
        end
    end

    assign o_valid     = r_valid;
    assign o_data      = r_data;
    assign o_valid_nxt = w_valid_nxt;

endmodule

// File: rtl/reg_pipe.sv
// Elastic DEPTH-stage register pipeline with bubble collapse, flush and occupancy count.
module reg_pipe
    import reg_pipe_pkg::*;
#(
    parameter int               WIDTH     = DEF_WIDTH,
    parameter int               DEPTH     = DEF_DEPTH,
    parameter logic [WIDTH-1:0] RESET_VAL = DEF_RESET_VAL[WIDTH-1:0]
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush,
    input  logic                          in_valid,
    input  logic [WIDTH-1:0]              in_data,
    output logic                          in_ready,
    output logic                          out_valid,
    output logic [WIDTH-1:0]              out_data,
    input  logic                          out_ready,
    output logic [occ_width(DEPTH)-1:0]   occupancy
);

    localparam int OW = occ_width(DEPTH);

    logic [DEPTH-1:0] w_valid;
    logic [DEPTH-1:0] w_valid_nxt;
    logic [DEPTH-1:0] w_ready;
    logic [WIDTH-1:0] w_data [DEPTH];
    logic             w_rdy_chain;
    logic [OW-1:0]    w_occ_nxt;
    logic [OW-1:0]    r_occupancy;

    // A slot may load when it is empty or its item moves on this cycle;
    // the chain only reads registered valid bits, so out_* never sees in_*.
    always_comb begin
        w_rdy_chain = out_ready;
        w_ready     = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            w_rdy_chain = ~w_valid[k] | w_rdy_chain;
            w_ready[k]  = w_rdy_chain;
        end
    end

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        logic             w_up_valid;
        logic [WIDTH-1:0] w_up_data;

        if (k == 0) begin : g_head
            assign w_up_valid = in_valid;
            assign w_up_data  = in_data;
        end else begin : g_body
            assign w_up_valid = w_valid[k-1];
            assign w_up_data  = w_data[k-1];
        end

        reg_pipe_stage #(
            .WIDTH     (WIDTH),
            .RESET_VAL (RESET_VAL)
        ) u_stage (
            .clk         (clk),
            .rst         (rst),
            .flush       (flush),
            .i_ready     (w_ready[k]),
            .i_up_valid  (w_up_valid),
            .i_up_data   (w_up_data),
            .o_valid     (w_valid[k]),
            .o_data      (w_data[k]),
            .o_valid_nxt (w_valid_nxt[k])
        );
    end

    // Population count of the valid bits the stages will hold after this edge.
    always_comb begin
        w_occ_nxt = '0;
        for (int k = 0; k < DEPTH; k++) begin
            w_occ_nxt = w_occ_nxt + OW'(w_valid_nxt[k]);
        end
    end

    // Occupancy register tracks the stage valid bits edge for edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_occupancy <= '0;
        end else begin
            r_occupancy <= w_occ_nxt;
        end
    end

    assign in_ready  = w_ready[0] & ~flush & ~rst;
    assign out_valid = w_valid[DEPTH-1];
    assign out_data  = w_data[DEPTH-1];
    assign occupancy = r_occupancy;

endmodule

// File: tb/tb_reg_pipe.sv
// Directed self-checking bench for reg_pipe (DEPTH=3 with RESET_VAL=A5, and DEPTH=1).
module tb_reg_pipe;

    logic       clk = 1'b0;
    logic       rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic [7:0] in_data, out_data;
    logic [1:0] occupancy;

    logic       rst1, flush1, in_valid1, in_ready1, out_valid1, out_ready1;
    logic [7:0] in_data1, out_data1;
    logic [0:0] occupancy1;

    int n_cmp = 0;
    int n_mis = 0;

    always #5 clk = ~clk;

    reg_pipe #(.WIDTH(8), .DEPTH(3), .RESET_VAL(8'hA5)) u_dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
        .out_ready(out_ready), .occupancy(occupancy)
    );

    reg_pipe #(.WIDTH(8), .DEPTH(1), .RESET_VAL(8'h00)) u_dut1 (
        .clk(clk), .rst(rst1), .flush(flush1), .in_valid(in_valid1), .in_data(in_data1),
        .in_ready(in_ready1), .out_valid(out_valid1), .out_data(out_data1),
        .out_ready(out_ready1), .occupancy(occupancy1)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int         idx, nxt;
        logic       acc;
        logic [7:0] bub [3];
        bub = '{8'h11, 8'h22, 8'h33};

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
        rst1 = 1'b1; flush1 = 1'b0; in_valid1 = 1'b0; in_data1 = 8'h00; out_ready1 = 1'b0;
        tick();
        tick();
        check_eq("rst_in_ready", 64'(in_ready), 64'd0);
        check_eq("rst_out_valid", 64'(out_valid), 64'd0);
        check_eq("rst_out_data", 64'(out_data), 64'hA5);
        check_eq("rst_occ", 64'(occupancy), 64'd0);
        check_eq("rst1_out_data", 64'(out_data1), 64'h00);
        check_eq("rst1_occ", 64'(occupancy1), 64'd0);
        rst = 1'b0; rst1 = 1'b0;
        #1;
        check_eq("post_rst_in_ready", 64'(in_ready), 64'd1);
        check_eq("post_rst1_in_ready", 64'(in_ready1), 64'd1);
        tick();

        // streaming: 1..4 back to back, output 3 cycles later
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_valid = (i < 4);
            in_data  = 8'(i + 1);
            #1;
            check_eq("stream_out_valid", 64'(out_valid), 64'((i >= 3) && (i <= 6)));
            if ((i >= 3) && (i <= 6)) check_eq("stream_out_data", 64'(out_data), 64'(i - 2));
            if (i < 4) check_eq("stream_in_ready", 64'(in_ready), 64'd1);
            if (i == 4 || i == 7) check_eq("stream_occ", 64'(occupancy), (i == 4) ? 64'd3 : 64'd0);
            tick();
        end

        // backpressure: offer 1..5 with out_ready low
        out_ready = 1'b0;
        idx = 1;
        for (int c = 0; c < 6; c++) begin
            in_valid = 1'b1;
            in_data  = 8'(idx);
            #1;
            acc = in_ready;
            tick();
            if (acc) idx++;
        end
        in_valid = 1'b1;
        in_data  = 8'(idx);
        #1;
        check_eq("bp_accepted", 64'(idx - 1), 64'd3);
        check_eq("bp_in_ready", 64'(in_ready), 64'd0);
        check_eq("bp_occ", 64'(occupancy), 64'd3);
        check_eq("bp_head", 64'(out_data), 64'd1);
        tick();
        check_eq("bp_hold_data", 64'(out_data), 64'd1);
        check_eq("bp_hold_occ", 64'(occupancy), 64'd3);
        out_ready = 1'b1;
        nxt = 1;
        for (int c = 0; c < 12; c++) begin
            if (nxt > 5) break;
            in_valid = (idx <= 5);
            in_data  = 8'(idx);
            #1;
            if (c == 0) check_eq("full_pass_in_ready", 64'(in_ready), 64'd1);
            if (c == 1) check_eq("full_pass_occ", 64'(occupancy), 64'd3);
            if (out_valid) begin
                check_eq("bp_order", 64'(out_data), 64'(nxt));
                nxt++;
            end
            acc = in_valid & in_ready;
            tick();
            if (acc) idx++;
        end
        check_eq("bp_exit_count", 64'(nxt - 1), 64'd5);
        in_valid = 1'b0;
        #1;
        check_eq("bp_empty_occ", 64'(occupancy), 64'd0);
        tick();

        // bubble collapse: lone item at stage 2, then two new items fill behind it
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'h11;
        #1;
        check_eq("bub_in_ready0", 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        check_eq("bub_single_occ", 64'(occupancy), 64'd1);
        check_eq("bub_single_data", 64'(out_data), 64'h11);
        in_valid = 1'b1;
        in_data  = 8'h22;
        #1;
        check_eq("bub_in_ready1", 64'(in_ready), 64'd1);
        tick();
        in_data = 8'h33;
        #1;
        check_eq("bub_in_ready2", 64'(in_ready), 64'd1);
        tick();
        in_valid = 1'b0;
        #1;
        check_eq("bub_full_occ", 64'(occupancy), 64'd3);
        check_eq("bub_head_kept", 64'(out_data), 64'h11);
        tick();
        out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            check_eq("bub_out_valid", 64'(out_valid), 64'd1);
            check_eq("bub_out_data", 64'(out_data), 64'(bub[c]));
            tick();
        end

        // flush with a concurrent input
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'hAA;
        tick();
        in_data = 8'hBB;
        tick();
        #1;
        check_eq("flush_pre_occ", 64'(occupancy), 64'd2);
        flush    = 1'b1;
        in_data  = 8'hCC;
        #1;
        check_eq("flush_in_ready", 64'(in_ready), 64'd0);
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        #1;
        check_eq("flush_occ", 64'(occupancy), 64'd0);
        check_eq("flush_out_valid", 64'(out_valid), 64'd0);
        check_eq("flush_data_hold", 64'(out_data), 64'h33);
        check_eq("flush_in_ready_after", 64'(in_ready), 64'd1);
        out_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            check_eq("flush_no_leak", 64'(out_valid), 64'd0);
        end

        // reset asserted mid-stream beats flush and transfers
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int c = 0; c < 3; c++) begin
            in_data = 8'(c + 1);
            tick();
        end
        rst       = 1'b1;
        flush     = 1'b1;
        out_ready = 1'b1;
        in_data   = 8'h44;
        #1;
        check_eq("mid_rst_in_ready", 64'(in_ready), 64'd0);
        tick();
        check_eq("mid_rst_occ", 64'(occupancy), 64'd0);
        check_eq("mid_rst_out_valid", 64'(out_valid), 64'd0);
        check_eq("mid_rst_out_data", 64'(out_data), 64'hA5);
        rst      = 1'b0;
        flush    = 1'b0;
        in_valid = 1'b0;
        #1;
        check_eq("mid_rst_release_ready", 64'(in_ready), 64'd1);
        tick();

        // DEPTH=1 slice with out_ready toggling
        for (int c = 0; c < 8; c++) begin
            out_ready1 = ((c % 2) == 0);
            in_valid1  = 1'b1;
            in_data1   = 8'h3C;
            #1;
            check_eq("d1_out_valid", 64'(out_valid1), 64'(c >= 1));
            check_eq("d1_in_ready", 64'(in_ready1), 64'((c == 0) || ((c % 2) == 0)));
            check_eq("d1_occ", 64'(occupancy1), 64'(c >= 1));
            if (c >= 1) check_eq("d1_out_data", 64'(out_data1), 64'h3C);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
